pc_delay_pipe: RTL
==================

Name: pc_delay_pipe

Overview:
- Parametrised successor of the single-register PC delay.
- A DEPTH-stage PC delay line with a per-stage valid bit. It keeps the fetch PC aligned with the instruction leaving a multi-cycle instruction memory (BRAM with MAR/MDR plus optional extra pipeline registers).
- Adds over the old block: stall hold, flush, jump redirect with wrong-path squash, per-stage valid tracking and occupancy count.
- Sits between the PC generator and the decode stage.

Parameters:
- PC_WIDTH, 32, width of PC values.
- DEPTH, 2, number of delay stages, legal range 1..8.
- RESET_PC, 0, PC value loaded into every stage on reset or when disabled.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- work_ena  input  1  core enable; low forces the disabled state.
- stall  input  1  hold all stages.
- flush  input  1  invalidate all stages.
- pc_jump  input  1  redirect: load pc_target into stage 0 and squash younger-path stages.
- pc_target  input  PC_WIDTH  redirect PC.
- pc_i  input  PC_WIDTH  PC from the PC generator.
- pc_valid_i  input  1  pc_i is a real fetch.
- pc_o  output  PC_WIDTH  PC of the last stage (matches the instruction).
- valid_o  output  1  valid bit of the last stage.
- stage_valid_o  output  DEPTH  valid bits of all stages; bit k = stage k.
- occupancy_o  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Storage is s_pc[k] and s_v[k] for k = 0..DEPTH-1. Stage 0 is youngest; stage DEPTH-1 drives pc_o and valid_o.
- All registers update on the rising edge of clk. Exactly one action applies per cycle, in this priority order:
  1. rst=1: all s_pc = RESET_PC, all s_v = 0.
  2. work_ena=0: same as reset (s_pc = RESET_PC, s_v = 0).
  3. flush=1: all s_v = 0; s_pc values hold. pc_jump and stall are ignored this cycle.
  4. pc_jump=1: s_pc[0] = pc_target, s_v[0] = 1. Stages 1..DEPTH-1 get s_v = 0 with s_pc holding. pc_jump overrides stall.
  5. stall=1: all stages hold pc and valid. pc_i and pc_valid_i are dropped; upstream must also hold.
  6. Otherwise advance: s_pc[0] = pc_i, s_v[0] = pc_valid_i; s_pc[k] = s_pc[k-1] and s_v[k] = s_v[k-1] for k >= 1.
- Outputs:
  - pc_o = s_pc[DEPTH-1] and valid_o = s_v[DEPTH-1], both registered with no combinational path from inputs.
  - stage_valid_o = {s_v[DEPTH-1..0]}.
  - occupancy_o = popcount(s_v), combinational from registers only.
- Latency: a pc_i accepted in cycle t with no stall appears on pc_o after DEPTH rising edges. Each stall cycle adds one cycle.
- DEPTH=1 is the degenerate case: behaviour equals a single register with jump and stall. The squash affects no stages.
- Reset state: pc_o = RESET_PC, valid_o = 0, stage_valid_o = 0, occupancy_o = 0.
- Reset or work_ena low in mid-operation discards all in-flight PCs on that edge. There is no partial drain.
- Simultaneous flush and pc_jump: flush wins, and the target is lost. The PC generator re-issues it.
- pc_valid_i=0 in the advance case inserts a bubble; pc_i is still captured into s_pc[0].
- No X propagation: every register has a defined reset value.

Test Plan:
- DEPTH=2: reset, then drive pc_i = 0x00, 0x04, 0x08 with valid=1 on consecutive cycles.
  -> pc_o is 0x00, 0x04, 0x08 on cycles 2, 3, 4 after first drive; valid_o=1; occupancy_o reaches 2.
- DEPTH=2 after pipeline full (stages 0x10, 0x0C): stall=1 for 3 cycles with pc_i changing.
  -> pc_o stays 0x0C and stage_valid_o stays 2'b11. After release, 0x10 then the new pc_i advance.
- DEPTH=2 full: pc_jump=1 with pc_target=0x100.
  -> next cycle stage_valid_o=2'b01, occupancy_o=1, valid_o=0. One cycle later pc_o=0x100 with valid_o=1.
- pc_jump=1 and stall=1 together.
  -> jump is taken: stage 0 = target, older stages squashed.
- flush=1 and pc_jump=1 together on a full pipe.
  -> all valid 0, occupancy_o=0; pc_target is not loaded.
- work_ena=0 for 1 cycle mid-stream, then rst=1 mid-stream, with RESET_PC=0x80 in a second build.
  -> each time pc_o=0x80, valid_o=0, occupancy_o=0 on the next edge. The stream resumes with the full DEPTH latency.

Source files
------------

// File: rtl/pc_delay_pipe.sv
// pc_delay_pipe
//   Multi-stage PC delay line. It keeps the fetch PC aligned with the
//   instruction that leaves a multi-cycle instruction memory. Each stage
//   holds a PC and a valid bit. Stage 0 is the youngest stage, and stage
//   DEPTH-1 drives the outputs.
//
//   One action applies per rising edge, from highest to lowest priority:
//     1. reset
//     2. disable (work_ena low)
//     3. flush
//     4. jump redirect
//     5. stall
//     6. advance
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   work_ena       core enable; low behaves like reset
//   stall          hold every stage
//   flush          clear every valid bit; PCs hold
//   pc_jump        load pc_target into stage 0, squash older stages
//   pc_target      redirect PC
//   pc_i           PC from the PC generator
//   pc_valid_i     pc_i is a real fetch (low inserts a bubble)
//   pc_o           PC of the last stage
//   valid_o        valid bit of the last stage
//   stage_valid_o  valid bits of all stages, bit k = stage k
//   occupancy_o    number of valid stages
module pc_delay_pipe #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    localparam int                 OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                work_ena,
    input  logic                stall,
    input  logic                flush,
    input  logic                pc_jump,
    input  logic [PC_WIDTH-1:0] pc_target,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                pc_valid_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                valid_o,
    output logic [DEPTH-1:0]    stage_valid_o,
    output logic [OCC_W-1:0]    occupancy_o
);

    logic [PC_WIDTH-1:0] s_pc [DEPTH];
    logic [DEPTH-1:0]    s_v;

    always_ff @(posedge clk) begin
        if (rst || !work_ena) begin
            for (int k = 0; k < DEPTH; k++) begin
                s_pc[k] <= RESET_PC;
            end
            s_v <= '0;
        end else if (flush) begin
            // A simultaneous jump target is lost here.
            // The PC generator re-issues it.
            s_v <= '0;
        end else if (pc_jump) begin
            // Jump overrides stall. Older stages hold their PC but are squashed.
            s_pc[0] <= pc_target;
            s_v     <= '0;
            s_v[0]  <= 1'b1;
        end else if (!stall) begin
            s_pc[0] <= pc_i;
            s_v[0]  <= pc_valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                s_pc[k] <= s_pc[k-1];
                s_v[k]  <= s_v[k-1];
            end
        end
    end

    assign pc_o          = s_pc[DEPTH-1];
    assign valid_o       = s_v[DEPTH-1];
    assign stage_valid_o = s_v;

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(s_v[k]);
        end
    end

endmodule
